// File: rtl/game_pkg.sv
// Shared definitions for the game-level state controller: state encoding and counter widths.
package game_pkg;

    localparam int unsigned LIVES_W_DEF = 4;
    localparam int unsigned FRAME_CNT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RESPAWN = 2'd2,
        ST_OVER    = 2'd3
    } game_state_e;

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter advanced by frame ticks; o_Done flags the tick that takes it from 1 to 0.
module frame_timer #(
    parameter int unsigned W = 10
) (
    input  logic         i_Clk,
    input  logic         i_Reset_n,
    input  logic         i_Load,
    input  logic [W-1:0] i_Load_Val,
    input  logic         i_Tick,
    output logic         o_Done
);

    logic [W-1:0] r_count;

    // Load beats a coincident tick; the count saturates at zero.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_count <= '0;
        end else if (i_Load) begin
            r_count <= i_Load_Val;
        end else if (i_Tick && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_Done = i_Tick & (r_count == W'(1));

endmodule

// File: rtl/game_state_ctrl.sv
// Game-level FSM: start, life-loss respawn window and game over, with registered outputs.
// Optional sprite blink during respawn is built only when GAME_STATE_BLINK_EN is defined.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES_W        = LIVES_W_DEF,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter int unsigned BLINK_FRAMES   = 8
) (
    input  logic               i_Clk,
    input  logic               i_Reset_n,
    input  logic               i_Start,
    input  logic               i_Frame_Tick,
    input  logic [LIVES_W-1:0] i_Lives,
    output logic [1:0]         o_State,
    output logic               o_Play_En,
    output logic               o_Collision_Mask,
    output logic               o_Lives_Reset,
    output logic               o_Respawn,
    output logic               o_Game_Over,
    output logic               o_Blink
);

    if ((RESPAWN_FRAMES == 0) || (RESPAWN_FRAMES > 1023)) begin : g_bad_respawn
        $error("RESPAWN_FRAMES must be within 1..1023");
    end
    if ((BLINK_FRAMES == 0) || (BLINK_FRAMES > 1023)) begin : g_bad_blink
        $error("BLINK_FRAMES must be within 1..1023");
    end

    game_state_e        r_state;
    game_state_e        w_state_next;
    logic               r_start;
    logic [LIVES_W-1:0] r_lives;
    logic               r_play_en;
    logic               r_mask;
    logic               r_lives_reset;
    logic               r_respawn;
    logic               r_game_over;

    logic w_start_rise;
    logic w_loss;
    logic w_lives_zero;
    logic w_timer_load;
    logic w_timer_done;
    logic w_lives_reset_next;
    logic w_respawn_next;

    assign w_start_rise = i_Start & ~r_start;
    assign w_loss       = i_Lives < r_lives;
    assign w_lives_zero = (i_Lives == '0);

    frame_timer #(
        .W (FRAME_CNT_W)
    ) u_respawn_timer (
        .i_Clk      (i_Clk),
        .i_Reset_n  (i_Reset_n),
        .i_Load     (w_timer_load),
        .i_Load_Val (FRAME_CNT_W'(RESPAWN_FRAMES)),
        .i_Tick     (i_Frame_Tick),
        .o_Done     (w_timer_done)
    );

    always_comb begin
        w_state_next       = r_state;
        w_timer_load       = 1'b0;
        w_lives_reset_next = 1'b0;
        w_respawn_next     = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (w_start_rise) begin
                    w_state_next       = ST_PLAY;
                    w_lives_reset_next = 1'b1;
                end
            end
            ST_PLAY: begin
                if (w_lives_zero && (r_lives != '0)) begin
                    w_state_next = ST_OVER;
                end else if (w_loss) begin
                    w_state_next = ST_RESPAWN;
                    w_timer_load = 1'b1;
                end
            end
            ST_RESPAWN: begin
                // Running out of lives outranks the final respawn tick.
                if (w_lives_zero) begin
                    w_state_next = ST_OVER;
                end else if (w_timer_done) begin
                    w_state_next   = ST_PLAY;
                    w_respawn_next = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state       <= ST_IDLE;
            r_start       <= 1'b0;
            r_lives       <= '0;
            r_play_en     <= 1'b0;
            r_mask        <= 1'b1;
            r_lives_reset <= 1'b0;
            r_respawn     <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_start       <= i_Start;
            r_lives       <= i_Lives;
            r_play_en     <= (w_state_next == ST_PLAY);
            r_mask        <= (w_state_next != ST_PLAY);
            r_lives_reset <= w_lives_reset_next;
            r_respawn     <= w_respawn_next;
            r_game_over   <= (w_state_next == ST_OVER);
        end
    end

`ifdef GAME_STATE_BLINK_EN
    logic w_blink_done;
    logic r_blink;

    // Reloads itself each period so the blink keeps running for the whole window.
    frame_timer #(
        .W (FRAME_CNT_W)
    ) u_blink_timer (
        .i_Clk      (i_Clk),
        .i_Reset_n  (i_Reset_n),
        .i_Load     (w_timer_load | w_blink_done),
        .i_Load_Val (FRAME_CNT_W'(BLINK_FRAMES)),
        .i_Tick     (i_Frame_Tick),
        .o_Done     (w_blink_done)
    );

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_blink <= 1'b0;
        end else if (w_state_next != ST_RESPAWN) begin
            r_blink <= 1'b0;
        end else if (r_state != ST_RESPAWN) begin
            r_blink <= 1'b1;
        end else begin
            r_blink <= r_blink ^ w_blink_done;
        end
    end

    assign o_Blink = r_blink;
`else
    assign o_Blink = 1'b0;
`endif

    assign o_State          = r_state;
    assign o_Play_En        = r_play_en;
    assign o_Collision_Mask = r_mask;
    assign o_Lives_Reset    = r_lives_reset;
    assign o_Respawn        = r_respawn;
    assign o_Game_Over      = r_game_over;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: cycle-level game model plus directed scenarios with literal checks.
module tb_game_state_ctrl;

    localparam int unsigned LW = 4;
    localparam int unsigned RF = 60;
    localparam int unsigned BF = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          tick  = 1'b0;
    logic [LW-1:0] lives = '0;

    logic [1:0] st;
    logic       play_en, mask, lr, resp, over, blink;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    game_state_ctrl #(
        .LIVES_W        (LW),
        .RESPAWN_FRAMES (RF),
        .BLINK_FRAMES   (BF)
    ) dut (
        .i_Clk            (clk),
        .i_Reset_n        (rst_n),
        .i_Start          (start),
        .i_Frame_Tick     (tick),
        .i_Lives          (lives),
        .o_State          (st),
        .o_Play_En        (play_en),
        .o_Collision_Mask (mask),
        .o_Lives_Reset    (lr),
        .o_Respawn        (resp),
        .o_Game_Over      (over),
        .o_Blink          (blink)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: 0 idle, 1 play, 2 respawn, 3 over; counts respawn ticks upward.
    int m_state      = 0;
    int m_ticks      = 0;
    int m_lives_prev = 0;
    bit m_start_prev = 1'b0;
    bit m_lr         = 1'b0;
    bit m_resp       = 1'b0;
    int exp_blink;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_ticks = 0; m_lives_prev = 0;
            m_start_prev = 1'b0; m_lr = 1'b0; m_resp = 1'b0;
        end else begin
            m_lr   = 1'b0;
            m_resp = 1'b0;
            if (m_state == 0 || m_state == 3) begin
                if (start && !m_start_prev) begin
                    m_state = 1;
                    m_lr    = 1'b1;
                end
            end else if (m_state == 1) begin
                if (int'(lives) == 0 && m_lives_prev != 0) m_state = 3;
                else if (int'(lives) < m_lives_prev) begin
                    m_state = 2;
                    m_ticks = 0;
                end
            end else begin
                if (int'(lives) == 0) m_state = 3;
                else if (tick) begin
                    m_ticks++;
                    if (m_ticks == RF) begin
                        m_state = 1;
                        m_resp  = 1'b1;
                    end
                end
            end
            m_start_prev = start;
            m_lives_prev = int'(lives);
        end
`ifdef GAME_STATE_BLINK_EN
        exp_blink = (m_state == 2 && ((m_ticks / BF) % 2) == 0) ? 1 : 0;
`else
        exp_blink = 0;
`endif
        #1;
        chk("cyc_state", 32'(st), m_state);
        chk("cyc_play_en", 32'(play_en), (m_state == 1) ? 1 : 0);
        chk("cyc_mask", 32'(mask), (m_state != 1) ? 1 : 0);
        chk("cyc_lives_reset", 32'(lr), int'(m_lr));
        chk("cyc_respawn", 32'(resp), int'(m_resp));
        chk("cyc_game_over", 32'(over), (m_state == 3) ? 1 : 0);
        chk("cyc_blink", 32'(blink), exp_blink);
    end

    task automatic step(input bit s, input bit t, input int l);
        @(negedge clk);
        start = s;
        tick  = t;
        lives = LW'(l);
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n, input int l);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, l);
            step(1'b0, 1'b0, l);
        end
    endtask

    initial begin
        #12;
        chk("lit_reset_state", 32'(st), 0);
        chk("lit_reset_mask", 32'(mask), 1);
        chk("lit_reset_play", 32'(play_en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 3);
        step(0, 0, 3);

        // Start press: lives-reset pulse and PLAY on the same following cycle.
        step(1, 0, 3);
        chk("lit_start_lr", 32'(lr), 1);
        chk("lit_start_state", 32'(st), 1);
        chk("lit_start_play", 32'(play_en), 1);
        chk("lit_start_mask", 32'(mask), 0);
        step(1, 0, 3);
        chk("lit_start_lr_once", 32'(lr), 0);
        step(0, 0, 3);

        // Life lost, full respawn window.
        step(0, 0, 2);
        chk("lit_loss_state", 32'(st), 2);
        chk("lit_loss_mask", 32'(mask), 1);
`ifdef GAME_STATE_BLINK_EN
        chk("lit_blink_entry", 32'(blink), 1);
`else
        chk("lit_blink_entry", 32'(blink), 0);
`endif
        ticks(59, 2);
        chk("lit_tick59_state", 32'(st), 2);
        step(0, 1, 2);
        chk("lit_tick60_state", 32'(st), 1);
        chk("lit_tick60_resp", 32'(resp), 1);
        step(0, 0, 2);
        chk("lit_resp_once", 32'(resp), 0);
        step(0, 0, 3);
        chk("lit_increase_play", 32'(st), 1);

        // Asynchronous reset in the middle of a respawn.
        step(0, 0, 1);
        ticks(29, 1);
        @(negedge clk);
        tick = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("lit_rst_mid_state", 32'(st), 0);
        chk("lit_rst_mid_mask", 32'(mask), 1);
        chk("lit_rst_mid_resp", 32'(resp), 0);
        chk("lit_rst_mid_lr", 32'(lr), 0);
        @(negedge clk);
        tick  = 1'b0;
        rst_n = 1'b1;

        // Restart, respawn down to one life, then lose it in PLAY with start held.
        step(0, 0, 3);
        step(1, 0, 3);
        chk("lit_restart_state", 32'(st), 1);
        step(0, 0, 3);
        step(0, 0, 1);
        ticks(59, 1);
        step(0, 1, 1);
        chk("lit_resp2_pulse", 32'(resp), 1);
        step(1, 0, 1);
        step(1, 0, 0);
        chk("lit_over_state", 32'(st), 3);
        chk("lit_over_flag", 32'(over), 1);
        chk("lit_over_resp", 32'(resp), 0);
        repeat (3) step(1, 0, 0);
        chk("lit_held_no_restart", 32'(st), 3);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("lit_repress_lr", 32'(lr), 1);
        chk("lit_repress_state", 32'(st), 1);
        step(0, 0, 0);
        step(0, 0, 3);

        // Zero lives on the final respawn tick: OVER wins.
        step(0, 0, 2);
        ticks(59, 2);
        step(0, 1, 0);
        chk("lit_tie_state", 32'(st), 3);
        chk("lit_tie_resp", 32'(resp), 0);

        // Zero lives partway through a respawn.
        step(0, 0, 3);
        step(1, 0, 3);
        step(0, 0, 3);
        step(0, 0, 2);
        ticks(5, 2);
        step(0, 0, 0);
        chk("lit_mid_over", 32'(st), 3);
        step(0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
